// File: rtl/synth_pkg.sv
// Shared synth types and constants.
// Used by the voice envelope, the synth core and the I2S transmitter.
package synth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

  localparam int SAMPLE_DIV = 1247;
  localparam int ENV_LVL_W  = 16;
  localparam int ENV_VOL_W  = 5;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick: one pulse every DIV+1 clocks.
// Voices share a reset, so their ticks stay phase-aligned.
module sample_tick_gen
  import synth_pkg::*;
#(
  parameter int DIV = SAMPLE_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV < 1) ? 1 : $clog2(DIV + 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: gate edges, state FSM, 16-bit level ramp.
// Define ENV_EXP_RELEASE_EN for an exponential release tail.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int DIV        = SAMPLE_DIV,
  parameter int STEP_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gate,
  input  logic [7:0]           atk_rate,
  input  logic [7:0]           dec_rate,
  input  logic [ENV_VOL_W-1:0] sus_lvl,
  input  logic [7:0]           rel_rate,
  output logic [ENV_VOL_W-1:0] vol,
  output logic                 active
);

  logic tick;

  sample_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  env_state_t           state_q, state_d;
  logic [ENV_LVL_W-1:0] level_q, level_d;
  logic                 gate_q;
  logic                 rise, fall;

  logic [ENV_LVL_W:0] lvl;
  logic [ENV_LVL_W:0] atk_step, dec_step, rel_step;
  logic [ENV_LVL_W:0] tgt, sum;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  assign lvl      = {1'b0, level_q};
  assign tgt      = {1'b0, sus_lvl, 11'b0};
  assign atk_step = 17'(atk_rate) << STEP_SHIFT;
  assign dec_step = 17'(dec_rate) << STEP_SHIFT;
  assign sum      = lvl + atk_step;

`ifdef ENV_EXP_RELEASE_EN
  // Step shrinks with level; the forced LSB keeps the tail moving to 0.
  assign rel_step = {1'b0,
    (level_q >> ({1'b0, rel_rate[3:0]} + 5'd1)) | 16'd1};
`else
  assign rel_step = 17'(rel_rate) << STEP_SHIFT;
`endif

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (rise) begin
      state_d = ATTACK;
    end else if (fall && state_q != IDLE) begin
      state_d = RELEASE;
    end else if (tick) begin
      unique case (state_q)
        IDLE: level_d = '0;
        ATTACK: begin
          if (atk_rate == '0 || sum >= 17'h0FFFF) begin
            level_d = '1;
            state_d = DECAY;
          end else begin
            level_d = sum[ENV_LVL_W-1:0];
          end
        end
        DECAY: begin
          if (dec_rate == '0 || lvl <= tgt + dec_step) begin
            level_d = tgt[ENV_LVL_W-1:0];
            state_d = SUSTAIN;
          end else begin
            level_d = 16'(lvl - dec_step);
          end
        end
        SUSTAIN: level_d = tgt[ENV_LVL_W-1:0];
        RELEASE: begin
          if (rel_rate == '0 || lvl <= rel_step) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = 16'(lvl - rel_step);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q  <= 1'b0;
      state_q <= IDLE;
      level_q <= '0;
      vol     <= '0;
      active  <= 1'b0;
    end else begin
      gate_q  <= gate;
      state_q <= state_d;
      level_q <= level_d;
      vol     <= level_q[ENV_LVL_W-1 -: ENV_VOL_W];
      active  <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: cycle model feeding a scoreboard,
// a table of settle-level vectors and hand-timed corner sequences.
module tb_adsr_envelope;
  import synth_pkg::*;

  logic       clk;
  logic       rst;
  logic       gate;
  logic [7:0] atk_rate, dec_rate, rel_rate;
  logic [4:0] sus_lvl;
  logic [4:0] vol;
  logic       active;

  int n_err;
  int n_chk;

  adsr_envelope #(
    .DIV(3),
    .STEP_SHIFT(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .gate    (gate),
    .atk_rate(atk_rate),
    .dec_rate(dec_rate),
    .sus_lvl (sus_lvl),
    .rel_rate(rel_rate),
    .vol     (vol),
    .active  (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Reference model: states 0..4 = idle/attack/decay/sustain/release
  int m_state, m_lvl, m_cnt, m_gq, m_vol, m_act;
  logic [5:0] sb[$];

  always @(posedge clk) begin : model
    int step, tgt, ns, nl;
    bit tk, rs, fl;
    if (rst) begin
      m_state = 0; m_lvl = 0; m_cnt = 0;
      m_gq = 0; m_vol = 0; m_act = 0;
    end else begin
      tk = (m_cnt == 3);
      m_cnt = tk ? 0 : m_cnt + 1;
      m_vol = m_lvl / 2048;
      rs = gate && (m_gq == 0);
      fl = !gate && (m_gq == 1);
      m_gq = gate ? 1 : 0;
      ns = m_state;
      nl = m_lvl;
      tgt = int'(sus_lvl) * 2048;
      if (rs) ns = 1;
      else if (fl && m_state != 0) ns = 4;
      else if (tk) begin
        case (m_state)
          1: begin
            step = int'(atk_rate) * 16;
            if (atk_rate == 0 || m_lvl + step >= 65535) begin
              nl = 65535; ns = 2;
            end else nl = m_lvl + step;
          end
          2: begin
            step = int'(dec_rate) * 16;
            if (dec_rate == 0 || m_lvl <= tgt + step) begin
              nl = tgt; ns = 3;
            end else nl = m_lvl - step;
          end
          3: nl = tgt;
          4: begin
`ifdef ENV_EXP_RELEASE_EN
            step = (m_lvl >> (int'(rel_rate[3:0]) + 1)) | 1;
`else
            step = int'(rel_rate) * 16;
`endif
            if (rel_rate == 0 || m_lvl <= step) begin
              nl = 0; ns = 0;
            end else nl = m_lvl - step;
          end
          default: nl = 0;
        endcase
      end
      m_act = (ns != 0) ? 1 : 0;
      m_state = ns;
      m_lvl = nl;
    end
    sb.push_back({m_vol[4:0], m_act[0]});
  end

  always @(negedge clk) begin : monitor
    logic [5:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_vol", int'(vol), int'(e[5:1]));
      chk("sb_active", int'(active), int'(e[0]));
    end
  end

  typedef struct {
    logic [7:0] atk, dec, rel;
    logic [4:0] sus;
    int         on_cyc, off_cyc;
    logic [4:0] vol_on;
    logic       act_on;
    logic [4:0] vol_off;
    logic       act_off;
  } vec_t;

  vec_t vecs[5];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_rates(input logic [7:0] a, input logic [7:0] d,
                           input logic [4:0] s, input logic [7:0] r);
    atk_rate = a;
    dec_rate = d;
    sus_lvl  = s;
    rel_rate = r;
  endtask

  task automatic wait_vol(input int v, input int bound);
    int n;
    n = 0;
    while (int'(vol) != v && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_vol", int'(vol), v);
  endtask

  initial begin
    int n, ticks, minv;
    n_err = 0;
    n_chk = 0;
    rst = 1'b1;
    gate = 1'b0;
    set_rates(8'd0, 8'd0, 5'd0, 8'd0);

    vecs[0] = '{8'd0,   8'd0,   8'd0,   5'd20, 40,   40,  5'd20, 1'b1, 5'd0, 1'b0};
    vecs[1] = '{8'd255, 8'd255, 8'd255, 5'd10, 200,  100, 5'd10, 1'b1, 5'd0, 1'b0};
    vecs[2] = '{8'd0,   8'd255, 8'd255, 5'd31, 60,   100, 5'd31, 1'b1, 5'd0, 1'b0};
    vecs[3] = '{8'd0,   8'd0,   8'd0,   5'd0,  40,   40,  5'd0,  1'b1, 5'd0, 1'b0};
    vecs[4] = '{8'd8,   8'd0,   8'd0,   5'd12, 2200, 20,  5'd12, 1'b1, 5'd0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_vol", int'(vol), 0);
    chk("rst_active", int'(active), 0);
    rst = 1'b0;

    // Idle with gate low; tick cadence 1 in 4
    ticks = 0;
    repeat (1000) begin
      @(negedge clk);
      if (dut.u_tick.tick) ticks++;
    end
    chk("tick_count", ticks, 250);
    chk("idle_vol", int'(vol), 0);

    for (int i = 0; i < 5; i++) begin
      gate = 1'b0;
      set_rates(vecs[i].atk, vecs[i].dec, vecs[i].sus, vecs[i].rel);
      do_reset();
      gate = 1'b1;
      repeat (vecs[i].on_cyc) @(negedge clk);
      chk($sformatf("v%0d_on_vol", i), int'(vol), int'(vecs[i].vol_on));
      chk($sformatf("v%0d_on_act", i), int'(active), int'(vecs[i].act_on));
      gate = 1'b0;
      repeat (vecs[i].off_cyc) @(negedge clk);
      chk($sformatf("v%0d_off_vol", i), int'(vol), int'(vecs[i].vol_off));
      chk($sformatf("v%0d_off_act", i), int'(active), int'(vecs[i].act_off));
    end

    // Attack 4080/tick: vol 31 at tick 16, FFFF and DECAY at tick 17
    gate = 1'b0;
    set_rates(8'd255, 8'd1, 5'd0, 8'd0);
    do_reset();
    gate = 1'b1;
    wait_vol(31, 500);
    repeat (2) @(negedge clk);
    chk("atk16_state", int'(dut.state_q), int'(ATTACK));
    @(negedge clk);
    chk("atk17_state", int'(dut.state_q), int'(DECAY));

    // Release at 0x4000, step 16: 1024 ticks to IDLE
    gate = 1'b0;
    set_rates(8'd64, 8'd0, 5'd31, 8'd1);
    do_reset();
    gate = 1'b1;
    wait_vol(8, 500);
    gate = 1'b0;
    n = 0;
    while (active && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("rel_cycles", n, 4095);
    chk("rel_vol", int'(vol), 0);
    chk("rel_state", int'(dut.state_q), int'(IDLE));

    // Re-trigger in release at 0x2000: attack resumes from there
    gate = 1'b0;
    set_rates(8'd64, 8'd0, 5'd31, 8'd128);
    do_reset();
    gate = 1'b1;
    wait_vol(8, 500);
    gate = 1'b0;
    wait_vol(4, 500);
    gate = 1'b1;
    minv = 31;
    repeat (300) begin
      @(negedge clk);
      if (int'(vol) < minv) minv = int'(vol);
    end
    chk("retrig_min_vol", minv, 4);
    chk("retrig_end_vol", int'(vol), 31);

    // Gate fall in a tick cycle: level held that tick
    gate = 1'b0;
    set_rates(8'd0, 8'd0, 5'd20, 8'd0);
    do_reset();
    gate = 1'b1;
    repeat (20) @(negedge clk);
    n = 0;
    while (!dut.u_tick.tick && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", int'(dut.u_tick.tick), 1);
    gate = 1'b0;
    repeat (4) @(negedge clk);
    chk("edge_tick_vol", int'(vol), 20);
    chk("edge_tick_act", int'(active), 1);
    @(negedge clk);
    chk("edge_tick_act2", int'(active), 0);
    @(negedge clk);
    chk("edge_tick_vol2", int'(vol), 0);

    // Reset mid-decay with gate held high
    set_rates(8'd0, 8'd1, 5'd0, 8'd0);
    do_reset();
    gate = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_dec_state", int'(dut.state_q), int'(DECAY));
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_vol", int'(vol), 0);
    chk("rst2_act", int'(active), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_act", int'(active), 1);
    chk("restart_state", int'(dut.state_q), int'(ATTACK));
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
